// File: rtl/dds_increment_slewer_if.sv
// Control/status bundle between the increment slewer and its register/DDS neighbours.
interface dds_increment_slewer_if #(
    parameter int WIDTH       = 32,
    parameter int DWELL_WIDTH = 16
);
    logic                   enable;
    logic [WIDTH-1:0]       target_increment;
    logic [WIDTH-1:0]       max_step;
    logic [DWELL_WIDTH-1:0] dwell_cycles;
    logic                   PLL_locked;
    logic [WIDTH-1:0]       increment_out;
    logic                   slewing;
    logic                   at_target;
    logic [15:0]            step_count;

    modport master (
        output enable, target_increment, max_step, dwell_cycles, PLL_locked,
        input  increment_out, slewing, at_target, step_count
    );

    modport slave (
        input  enable, target_increment, max_step, dwell_cycles, PLL_locked,
        output increment_out, slewing, at_target, step_count
    );
endinterface

// File: rtl/dds_increment_slewer.sv
// Ramps the DDS phase increment toward a software target in bounded steps,
// dwelling between steps and pausing while the downstream PLL is unlocked.
module dds_increment_slewer #(
    parameter int               WIDTH             = 32,
    parameter logic [WIDTH-1:0] DEFAULT_INCREMENT = 32'h33333333,
    parameter int               DWELL_WIDTH       = 16
) (
    input  logic                 clk_ref,
    input  logic                 clk_ref_aresetn,
    dds_increment_slewer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, STEP, DWELL} state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       inc_q, inc_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [15:0]            step_cnt_q, step_cnt_d;
    logic                   at_target_q, at_target_d;
    logic                   sync1_q, sync1_d;
    logic                   sync2_q, sync2_d;
    logic                   locked_s;
    logic                   need_step;

    // Differences are taken one bit wider so neither direction can wrap.
    function automatic logic [WIDTH-1:0] step_toward(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] tgt,
        input logic [WIDTH-1:0] step
    );
        logic [WIDTH:0] diff;
        logic           up;
        up   = (tgt >= cur);
        diff = up ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt});
        if (step == '0 || diff <= {1'b0, step})
            return tgt;
        else if (up)
            return cur + step;
        else
            return cur - step;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign locked_s  = sync2_q;
    assign need_step = bus.enable && (bus.target_increment != inc_q);

    always_comb begin
        state_d     = state_q;
        inc_d       = inc_q;
        dwell_d     = dwell_q;
        step_cnt_d  = step_cnt_q;
        at_target_d = (inc_q == bus.target_increment);
        sync1_d     = bus.PLL_locked;
        sync2_d     = sync1_q;

        case (state_q)
            IDLE: begin
                if (need_step && locked_s)
                    state_d = STEP;
            end
            STEP: begin
                inc_d      = step_toward(inc_q, bus.target_increment, bus.max_step);
                dwell_d    = bus.dwell_cycles;
                step_cnt_d = sat_inc16(step_cnt_q);
                state_d    = DWELL;
            end
            DWELL: begin
                // Loss of lock freezes both the counter and the state.
                if (locked_s) begin
                    if (dwell_q == '0)
                        state_d = need_step ? STEP : IDLE;
                    else
                        dwell_d = dwell_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_ref or negedge clk_ref_aresetn) begin
        if (!clk_ref_aresetn) begin
            state_q     <= IDLE;
            inc_q       <= DEFAULT_INCREMENT;
            dwell_q     <= '0;
            step_cnt_q  <= '0;
            at_target_q <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            inc_q       <= inc_d;
            dwell_q     <= dwell_d;
            step_cnt_q  <= step_cnt_d;
            at_target_q <= at_target_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
        end
    end

    assign bus.increment_out = inc_q;
    assign bus.slewing       = (state_q != IDLE);
    assign bus.at_target     = at_target_q;
    assign bus.step_count    = step_cnt_q;

endmodule

// File: doc/dds_increment_slewer.md
Name: dds_increment_slewer

Overview:
- Sits directly upstream of the DDS clock synthesizer in the clk_ref domain and drives its 32-bit phase-accumulator increment.
- Software writes a target increment. The block ramps the live increment toward it in bounded steps, with a programmable dwell between steps, so the downstream MMCM/PLL chain never sees a frequency jump large enough to lose lock.
- While the downstream PLL reports unlock, slewing pauses.

Parameters:
- WIDTH, 32: increment/accumulator width.
- DEFAULT_INCREMENT, 32'h33333333: reset value of increment_out (20 MHz from 100 MHz).
- DWELL_WIDTH, 16: width of the dwell counter and dwell_cycles.

Ports:
- clk_ref  in  1  block clock (DDS reference clock).
- clk_ref_aresetn  in  1  reset, asynchronous assert, active-low.
- enable  in  1  allow slewing; when low, the increment is frozen.
- target_increment  in  WIDTH  desired increment (quasi-static, bus-driven).
- max_step  in  WIDTH  largest per-step change; 0 = jump to target in a single step.
- dwell_cycles  in  DWELL_WIDTH  clk_ref cycles to wait after each step.
- PLL_locked  in  1  downstream lock status; asynchronous, synchronized internally.
- increment_out  out  WIDTH  live increment fed to the DDS accumulator.
- slewing  out  1  high whenever state != IDLE.
- at_target  out  1  registered (increment_out == target_increment).
- step_count  out  16  saturating count of steps taken since reset.

Behaviour:

Reset:
- Clock clk_ref; reset asynchronous and active-low on clk_ref_aresetn.
- On reset: increment_out=DEFAULT_INCREMENT, state=IDLE, slewing=0, at_target=0, step_count=0, dwell counter=0, lock synchronizer flops=0.
- Reset asserted mid-slew aborts immediately to these values.

Lock synchronizer:
- PLL_locked passes through a 2-FF synchronizer to give locked_s (2-cycle latency).

State machine (IDLE, STEP, DWELL):
- IDLE: at an edge where enable && locked_s && target_increment != increment_out, go to STEP.
- STEP (exactly 1 cycle):
  - increment_out updates at the edge leaving STEP.
  - Load dwell counter with dwell_cycles.
  - Go to DWELL.
  - step_count increments, saturating at 16'hFFFF.
- DWELL:
  - When the counter is 0 and locked_s=1, leave DWELL: go to STEP if enable && target != out, else IDLE.
  - Otherwise, if locked_s=1, decrement the counter.
  - If locked_s=0, the counter is frozen and the state is held.
  - dwell_cycles=0 gives a 1-cycle DWELL. dwell_cycles=N gives N+1 cycles in DWELL.
- enable low in DWELL: finish the dwell, then go to IDLE.
- enable low never alters increment_out.

Step arithmetic (unsigned):
- diff = |target - out|, computed at WIDTH+1 bits.
- If max_step==0 or diff <= max_step: out <= target.
- Else out <= out ± max_step, toward target.
- Never overshoots and never wraps past 0 or 2^WIDTH-1.
- target_increment is re-sampled at every STEP, so a target change mid-slew may reverse direction.
- If target == out at STEP entry (target changed during the last DWELL), the step leaves out unchanged and still counts.

Timing and outputs:
- Step cadence: increment_out changes once every dwell_cycles+2 cycles while slewing and locked.
- at_target is 1-cycle registered and valid regardless of state.

Test Plan:
1. Release reset, enable=0 -> increment_out=0x33333333, slewing=0, step_count=0; at_target=1 one cycle after reset release when target_increment=0x33333333.
2. Locked, target=0x33333433, max_step=0x40, dwell=3 -> out takes 0x33333373, 0x333333B3, 0x333333F3, 0x33333433 at 5-cycle spacing; then IDLE, at_target=1, step_count=4.
3. Start 0x33333333, target=0x33333350, max_step=0x10 -> 0x33333343, then exactly 0x33333350 (no overshoot); step_count=2.
4. max_step=0, target=0x30000000 -> single step to 0x30000000; slewing high for dwell_cycles+2 cycles.
5. PLL_locked dropped mid-DWELL -> out stable, counter frozen, slewing=1; after re-lock, the dwell resumes 2 cycles later and completes the remaining count.
6. Out=0xFFFFFF80, target=0xFFFFFFFF, max_step=0x100 -> one step to 0xFFFFFFFF, no wrap. Then assert reset mid-DWELL -> out=0x33333333, IDLE at once.
